ip_stride_multi: RTL and testbench



---
 rtl/ip_stride_multi.sv | 243 ++++++++++++++++++++++++
 tb/tb_ip_stride_multi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_stride_multi.sv
// IP-indexed stride prefetcher: a fully-associative LRU tracker table learns per-IP strides.
// Once confident, it issues up to a runtime degree of same-page prefetches, one per handshake.
module ip_stride_multi #(
    parameter int NUM_TRACKERS = 8,
    parameter int ADDR_W       = 64,
    parameter int LOG2_BLOCK   = 6,
    parameter int LOG2_PAGE    = 12,
    parameter int MAX_DEGREE   = 4,
    parameter int CONF_BITS    = 2,
    parameter int CONF_THRESH  = 2,
    localparam int CLA_W       = ADDR_W - LOG2_BLOCK,
    localparam int DEG_W       = $clog2(MAX_DEGREE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [ADDR_W-1:0] req_ip_i,
    input  logic [DEG_W-1:0]  degree_i,
    output logic              pf_valid_o,
    input  logic              pf_ready_i,
    output logic [ADDR_W-1:0] pf_addr_o,
    output logic [31:0]       issued_cnt_o
);

    localparam int AGE_W = $clog2(NUM_TRACKERS);
    localparam int IDX_W = AGE_W;
    localparam logic [CONF_BITS-1:0] CONF_MAX      = {CONF_BITS{1'b1}};
    localparam logic [31:0]          CONF_THRESH_W = 32'(CONF_THRESH);
    localparam logic [DEG_W-1:0]     MAX_DEG_W     = DEG_W'(MAX_DEGREE);
    localparam logic [AGE_W-1:0]     OLDEST_AGE    = AGE_W'(NUM_TRACKERS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Tracker table
    logic                 valid_r       [NUM_TRACKERS];
    logic [ADDR_W-1:0]    tag_r         [NUM_TRACKERS];
    logic [CLA_W-1:0]     last_cla_r    [NUM_TRACKERS];
    logic [CLA_W-1:0]     last_stride_r [NUM_TRACKERS];
    logic [CONF_BITS-1:0] conf_r        [NUM_TRACKERS];
    logic [AGE_W-1:0]     age_r         [NUM_TRACKERS];

    // Issue sequencer
    logic              pf_valid_r;
    logic [ADDR_W-1:0] pf_addr_r;
    logic [CLA_W-1:0]  stride_r;
    logic [DEG_W-1:0]  k_r;
    logic [DEG_W-1:0]  deg_r;
    logic [31:0]       cnt_r;

    logic [NUM_TRACKERS-1:0] match_s;
    logic                    hit_s;
    logic [IDX_W-1:0]        hit_idx_s;
    logic                    inv_any_s;
    logic [IDX_W-1:0]        inv_idx_s;
    logic [AGE_W-1:0]        max_age_s;
    logic [IDX_W-1:0]        max_idx_s;
    logic [IDX_W-1:0]        sel_idx_s;
    logic [AGE_W-1:0]        old_age_s;

    logic                 accept_s;
    logic [CLA_W-1:0]     cla_s;
    logic [CLA_W-1:0]     stride_s;
    logic                 stride_zero_s;
    logic                 stride_same_s;
    logic [CONF_BITS-1:0] hit_conf_s;
    logic [CONF_BITS-1:0] conf_new_s;
    logic [DEG_W-1:0]     eff_deg_s;
    logic [CLA_W-1:0]     cand_cla_s;
    logic [ADDR_W-1:0]    cand_addr_s;
    logic                 cand_same_page_s;
    logic                 trigger_s;

    logic              issue_hs_s;
    logic [CLA_W-1:0]  next_cla_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              next_same_page_s;
    logic              last_s;
    logic              unused_s;

    assign unused_s = ^req_addr_i[LOG2_BLOCK-1:0];

    // Tag match, lowest free slot and oldest slot searches over the table
    always_comb begin
        match_s   = '0;
        hit_s     = 1'b0;
        hit_idx_s = '0;
        inv_any_s = 1'b0;
        inv_idx_s = '0;
        max_age_s = '0;
        max_idx_s = '0;
        for (int i = NUM_TRACKERS - 1; i >= 0; i--) begin
            match_s[i] = valid_r[i] && (tag_r[i] == req_ip_i);
            hit_s      = hit_s | match_s[i];
            hit_idx_s  = match_s[i] ? IDX_W'(i) : hit_idx_s;
            inv_any_s  = inv_any_s | ~valid_r[i];
            inv_idx_s  = (!valid_r[i]) ? IDX_W'(i) : inv_idx_s;
        end
        for (int i = 0; i < NUM_TRACKERS; i++) begin
            max_idx_s = (age_r[i] > max_age_s) ? IDX_W'(i) : max_idx_s;
            max_age_s = (age_r[i] > max_age_s) ? age_r[i] : max_age_s;
        end
    end

    assign sel_idx_s = hit_s ? hit_idx_s : (inv_any_s ? inv_idx_s : max_idx_s);
    assign old_age_s = hit_s ? age_r[hit_idx_s] : OLDEST_AGE;

    assign accept_s      = req_valid_i && (state_r == ST_IDLE);
    assign cla_s         = req_addr_i[ADDR_W-1:LOG2_BLOCK];
    assign stride_s      = cla_s - last_cla_r[hit_idx_s];
    assign stride_zero_s = (stride_s == '0);
    assign stride_same_s = (stride_s == last_stride_r[hit_idx_s]);
    assign hit_conf_s    = conf_r[hit_idx_s];

    // Saturating confidence update for a non-zero-stride hit
    always_comb begin
        conf_new_s = hit_conf_s;
        if (stride_same_s) begin
            conf_new_s = (hit_conf_s == CONF_MAX) ? CONF_MAX : hit_conf_s + 1'b1;
        end else begin
            conf_new_s = (hit_conf_s == '0) ? '0 : hit_conf_s - 1'b1;
        end
    end

    assign eff_deg_s        = (degree_i > MAX_DEG_W) ? MAX_DEG_W : degree_i;
    assign cand_cla_s       = cla_s + stride_s;
    assign cand_addr_s      = {cand_cla_s, {LOG2_BLOCK{1'b0}}};
    assign cand_same_page_s = (cand_addr_s[ADDR_W-1:LOG2_PAGE] == req_addr_i[ADDR_W-1:LOG2_PAGE]);

    assign trigger_s = accept_s && hit_s && !stride_zero_s && stride_same_s &&
                       (32'(conf_new_s) >= CONF_THRESH_W) && (eff_deg_s != '0) &&
                       cand_same_page_s;

    // Each next candidate is one stride past the address currently on the channel
    assign issue_hs_s       = (state_r == ST_ISSUE) && pf_valid_r && pf_ready_i;
    assign next_cla_s       = pf_addr_r[ADDR_W-1:LOG2_BLOCK] + stride_r;
    assign next_addr_s      = {next_cla_s, {LOG2_BLOCK{1'b0}}};
    assign next_same_page_s = (next_addr_s[ADDR_W-1:LOG2_PAGE] == pf_addr_r[ADDR_W-1:LOG2_PAGE]);
    assign last_s           = (k_r == deg_r) || !next_same_page_s;

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_hs_s && last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Tracker table training and LRU ageing on each accepted access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TRACKERS; i++) begin
                valid_r[i]       <= 1'b0;
                tag_r[i]         <= '0;
                last_cla_r[i]    <= '0;
                last_stride_r[i] <= '0;
                conf_r[i]        <= '0;
                age_r[i]         <= '0;
            end
        end else if (accept_s) begin
            for (int i = 0; i < NUM_TRACKERS; i++) begin
                if (IDX_W'(i) == sel_idx_s) begin
                    age_r[i] <= '0;
                    if (!hit_s) begin
                        valid_r[i]       <= 1'b1;
                        tag_r[i]         <= req_ip_i;
                        last_cla_r[i]    <= cla_s;
                        last_stride_r[i] <= '0;
                        conf_r[i]        <= '0;
                    end else if (!stride_zero_s) begin
                        last_cla_r[i]    <= cla_s;
                        last_stride_r[i] <= stride_s;
                        conf_r[i]        <= conf_new_s;
                    end
                end else if (valid_r[i] && (age_r[i] < old_age_s)) begin
                    age_r[i] <= age_r[i] + AGE_W'(1);
                end
            end
        end
    end

    // Prefetch channel registers and the handshake counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid_r <= 1'b0;
            pf_addr_r  <= '0;
            stride_r   <= '0;
            k_r        <= '0;
            deg_r      <= '0;
            cnt_r      <= 32'd0;
        end else begin
            pf_valid_r <= (state_nxt_s == ST_ISSUE);
            if (trigger_s) begin
                pf_addr_r <= cand_addr_s;
                stride_r  <= stride_s;
                k_r       <= DEG_W'(1);
                deg_r     <= eff_deg_s;
            end else if (issue_hs_s) begin
                cnt_r <= cnt_r + 32'd1;
                if (!last_s) begin
                    k_r       <= k_r + DEG_W'(1);
                    pf_addr_r <= next_addr_s;
                end
            end
        end
    end

    assign req_ready_o  = (state_r == ST_IDLE);
    assign pf_valid_o   = pf_valid_r;
    assign pf_addr_o    = pf_addr_r;
    assign issued_cnt_o = cnt_r;

endmodule

// File: tb/tb_ip_stride_multi.sv
// Bench for ip_stride_multi: directed vector table, backpressure/reset sequence and
// randomized accesses checked against a recency-list stride model.
module tb_ip_stride_multi;

    localparam int AW   = 64;
    localparam int LB   = 6;
    localparam int CW   = AW - LB;
    localparam int N    = 8;
    localparam int MAXD = 4;

    typedef logic [CW-1:0] cla_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready_o;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_ip;
    logic [2:0]    degree;
    logic          pf_valid_o;
    logic          pf_ready;
    logic [AW-1:0] pf_addr_o;
    logic [31:0]   issued_cnt_o;

    ip_stride_multi #(
        .NUM_TRACKERS(N), .ADDR_W(AW), .LOG2_BLOCK(LB), .LOG2_PAGE(12),
        .MAX_DEGREE(MAXD), .CONF_BITS(2), .CONF_THRESH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr), .req_ip_i(req_ip), .degree_i(degree),
        .pf_valid_o(pf_valid_o), .pf_ready_i(pf_ready),
        .pf_addr_o(pf_addr_o), .issued_cnt_o(issued_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference model: table kept as a recency list, most recent first
    typedef struct {
        logic [63:0] ip;
        cla_t        last_cla;
        cla_t        ls;
        int          conf;
    } ment_t;

    ment_t       mtab[$];
    logic [63:0] exp_q[$];
    logic [31:0] mcnt;

    task automatic model_access(input logic [63:0] ip, input logic [63:0] addr, input int deg);
        cla_t  cla;
        cla_t  s;
        int    idx;
        int    d;
        bit    same;
        ment_t e;
        cla = addr[63:LB];
        idx = -1;
        exp_q.delete();
        foreach (mtab[i]) if (mtab[i].ip == ip) idx = i;
        if (idx < 0) begin
            if (mtab.size() == N) void'(mtab.pop_back());
            e.ip = ip; e.last_cla = cla; e.ls = '0; e.conf = 0;
            mtab.push_front(e);
            return;
        end
        e = mtab[idx];
        mtab.delete(idx);
        s = cla - e.last_cla;
        if (s != '0) begin
            same = (s == e.ls);
            if (same) e.conf = (e.conf < 3) ? e.conf + 1 : 3;
            else begin
                e.conf = (e.conf > 0) ? e.conf - 1 : 0;
                e.ls = s;
            end
            e.last_cla = cla;
            if (same && e.conf >= 2) begin
                d = (deg > MAXD) ? MAXD : deg;
                for (int j = 1; j <= d; j++) begin
                    cla_t        c;
                    logic [63:0] a;
                    c = cla + s * cla_t'(j);
                    a = {c, 6'b000000};
                    if (a[63:12] != addr[63:12]) break;
                    exp_q.push_back(a);
                end
            end
        end
        mtab.push_front(e);
        mcnt = mcnt + 32'(exp_q.size());
    endtask

    // One access from a negedge; follows the resulting issue burst until pf_valid_o drops
    task automatic do_access(input logic [63:0] ip, input logic [63:0] addr, input int deg,
                             input bit rnd, output int n_pf, output logic [63:0] first_pf);
        int cyc;
        n_pf = 0;
        first_pf = 64'h0;
        model_access(ip, addr, deg);
        chk("req_ready_idle", {63'b0, req_ready_o}, 64'd1);
        req_valid = 1'b1;
        req_ip    = ip;
        req_addr  = addr;
        degree    = deg[2:0];
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (pf_valid_o && cyc < 200) begin
            chk("req_ready_issue", {63'b0, req_ready_o}, 64'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pf_extra: got 0x%0h required no prefetch", pf_addr_o);
            end else begin
                chk("pf_addr", pf_addr_o, exp_q[0]);
            end
            pf_ready = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
            if (pf_ready) begin
                if (n_pf == 0) first_pf = pf_addr_o;
                n_pf++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got %0d cycles required below 200", cyc);
        end
        pf_ready = 1'b1;
        chk("pf_missing", 64'(exp_q.size()), 64'd0);
        chk("issued_cnt", {32'b0, issued_cnt_o}, {32'b0, mcnt});
    endtask

    typedef struct {
        logic [63:0] ip;
        logic [63:0] addr;
        int          deg;
        int          n_pf;
        logic [63:0] first_pf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [63:0] ip, input logic [63:0] addr, input int deg,
                       input int n_pf, input logic [63:0] first_pf);
        vec_t v;
        v.ip = ip; v.addr = addr; v.deg = deg; v.n_pf = n_pf; v.first_pf = first_pf;
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [63:0] f;
        logic [63:0] ips[10];
        logic [63:0] last_addr[10];
        int          strides[9];

        // Training, page clip, negative stride, degree corner
        add(64'h400, 64'h1000, 3, 0, 64'h0);
        add(64'h400, 64'h1040, 3, 0, 64'h0);
        add(64'h400, 64'h1080, 3, 0, 64'h0);
        add(64'h400, 64'h10C0, 3, 3, 64'h1100);
        add(64'h500, 64'h1E80, 4, 0, 64'h0);
        add(64'h500, 64'h1EC0, 4, 0, 64'h0);
        add(64'h500, 64'h1F00, 4, 0, 64'h0);
        add(64'h500, 64'h1F40, 4, 2, 64'h1F80);
        add(64'h600, 64'h3100, 2, 0, 64'h0);
        add(64'h600, 64'h30C0, 2, 0, 64'h0);
        add(64'h600, 64'h3080, 2, 0, 64'h0);
        add(64'h600, 64'h3040, 2, 1, 64'h3000);
        add(64'h700, 64'h5000, 0, 0, 64'h0);
        add(64'h700, 64'h5040, 0, 0, 64'h0);
        add(64'h700, 64'h5080, 0, 0, 64'h0);
        add(64'h700, 64'h50C0, 0, 0, 64'h0);
        add(64'h700, 64'h5100, 7, 4, 64'h5140);
        // LRU: nine IPs evict IP #0; its return misses so three strided accesses cannot trigger
        for (int i = 0; i < 9; i++) add(64'h900 + 64'(i) * 64'h100, 64'h8000 + 64'(i) * 64'h1000, 1, 0, 64'h0);
        add(64'h900, 64'h8040, 1, 0, 64'h0);
        add(64'h900, 64'h8080, 1, 0, 64'h0);
        add(64'h900, 64'h80C0, 1, 0, 64'h0);
        add(64'h1100, 64'h10040, 1, 0, 64'h0);
        add(64'h1100, 64'h10080, 1, 0, 64'h0);
        add(64'h1100, 64'h100C0, 1, 1, 64'h10100);

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = 64'h0;
        req_ip = 64'h0;
        degree = 3'd0;
        pf_ready = 1'b1;
        mcnt = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_pf_valid", {63'b0, pf_valid_o}, 64'd0);
        chk("rst_pf_addr", pf_addr_o, 64'd0);
        chk("rst_issued", {32'b0, issued_cnt_o}, 64'd0);
        chk("rst_req_ready", {63'b0, req_ready_o}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_access(vecs[i].ip, vecs[i].addr, vecs[i].deg, 1'b0, n, f);
            chk($sformatf("vec%0d_npf", i), 64'(n), 64'(vecs[i].n_pf));
            if (vecs[i].n_pf > 0) chk($sformatf("vec%0d_first", i), f, vecs[i].first_pf);
            if (i == 3) chk("train_issued", {32'b0, issued_cnt_o}, 64'd3);
        end

        // Backpressure, then reset in the middle of the burst
        do_access(64'hA00, 64'hB000, 3, 1'b0, n, f);
        do_access(64'hA00, 64'hB040, 3, 1'b0, n, f);
        do_access(64'hA00, 64'hB080, 3, 1'b0, n, f);
        pf_ready  = 1'b0;
        req_valid = 1'b1;
        req_ip    = 64'hA00;
        req_addr  = 64'hB0C0;
        degree    = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {63'b0, pf_valid_o}, 64'd1);
            chk("bp_addr", pf_addr_o, 64'hB100);
            chk("bp_ready", {63'b0, req_ready_o}, 64'd0);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'b0, pf_valid_o}, 64'd0);
        chk("mid_rst_issued", {32'b0, issued_cnt_o}, 64'd0);
        chk("mid_rst_ready", {63'b0, req_ready_o}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pf_ready = 1'b1;
        mtab.delete();
        mcnt = 32'd0;
        @(negedge clk);
        do_access(64'hA00, 64'hB100, 3, 1'b0, n, f);
        chk("post_rst_miss", 64'(n), 64'd0);
        do_access(64'hA00, 64'hB140, 3, 1'b0, n, f);
        do_access(64'hA00, 64'hB180, 3, 1'b0, n, f);
        do_access(64'hA00, 64'hB1C0, 3, 1'b0, n, f);
        chk("post_rst_retrain", 64'(n), 64'd3);

        // Randomized accesses over ten IPs (forces evictions) with random backpressure
        strides = '{1, 1, 1, 2, -1, -1, 0, 3, 5};
        for (int k = 0; k < 10; k++) begin
            ips[k] = 64'h4000 + 64'(k) * 64'h24;
            last_addr[k] = 64'h100000 + 64'(k) * 64'h10000 + 64'($urandom_range(63, 0)) * 64'h40;
        end
        for (int t = 0; t < 150; t++) begin
            int          k;
            int          s;
            logic [63:0] a;
            k = int'($urandom_range(9, 0));
            s = strides[$urandom_range(8, 0)];
            if ($urandom_range(7, 0) == 0) a = 64'h100000 + 64'(k) * 64'h10000 + 64'($urandom_range(63, 0)) * 64'h40;
            else a = last_addr[k] + 64'(longint'(s) * 64);
            last_addr[k] = a;
            do_access(ips[k], a, int'($urandom_range(7, 0)), 1'b1, n, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
